fetch_pc_unit: RTL

//   PC register and instruction-fetch sequencer that sits directly upstream of shift_left_pc.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/next_pc_sel.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SQUASH
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR
    } redirect_sel_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - priority select of jr > jump > branch redirect target
module next_pc_sel
    import mips_pkg::*;
(
    input  logic        i_enable,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    redirect_sel_t w_sel;

    always_comb begin
        w_sel = SEL_NONE;
        if (i_jr)
            w_sel = SEL_JR;
        else if (i_jump)
            w_sel = SEL_JUMP;
        else if (i_branch_taken)
            w_sel = SEL_BRANCH;
    end

    always_comb begin
        o_target = 32'd0;
        case (w_sel)
            SEL_JR:     o_target = align_word(i_jr_target);
            SEL_JUMP:   o_target = align_word(i_jump_target);
            SEL_BRANCH: o_target = align_word(i_branch_target);
            default:    o_target = 32'd0;
        endcase
    end

    assign o_redirect = i_enable && (w_sel != SEL_NONE);

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register and fetch sequencer with one-entry decode buffer
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_addr;
    logic [31:0]  r_pending;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;

    logic         w_consume;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_ack;

    assign w_consume = r_valid & ~stall;
    assign w_ack     = imem_req & imem_ack;

    next_pc_sel u_next_pc_sel (
        .i_enable        (w_consume),
        .i_jr            (jr),
        .i_jr_target     (jr_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_redirect      (w_redirect),
        .o_target        (w_target)
    );

    // Request only when the buffer will have room at the next edge.
    always_comb begin
        imem_req = 1'b0;
        case (r_state)
            ST_FETCH:  imem_req = ~r_valid | w_consume;
            ST_SQUASH: imem_req = 1'b1;
            default:   imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fetch_addr <= RESET_PC;
            r_pending    <= RESET_PC;
            r_pc         <= RESET_PC;
            r_instr      <= 32'd0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (w_ack) begin
                        if (w_redirect) begin
                            r_valid      <= 1'b0;
                            r_fetch_addr <= w_target;
                        end else begin
                            r_instr      <= imem_rdata;
                            r_pc         <= r_fetch_addr;
                            r_valid      <= 1'b1;
                            r_fetch_addr <= r_fetch_addr + PC_STEP;
                        end
                    end else if (w_redirect) begin
                        // The outstanding request must complete before the target can be issued.
                        r_pending <= w_target;
                        r_valid   <= 1'b0;
                        r_state   <= ST_SQUASH;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                end
                ST_SQUASH: begin
                    if (imem_ack) begin
                        r_fetch_addr <= r_pending;
                        r_state      <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_addr   = r_fetch_addr;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + PC_STEP;
    assign instr       = r_instr;
    assign instr_valid = r_valid;

endmodule
